// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store against a word SRAM
// with programmable access latency and registered valid/ready response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load_code,
  input  logic [1:0]  req_store_code,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    lcode_q, lcode_d;
  logic [1:0]    scode_q, scode_d;
  logic          ready_d, valid_d, err_d;
  logic [31:0]   rdata_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [IW-1:0] idx;
  logic          is_half, is_word, bad_code, misaligned, out_of_range, acc_err;
  logic [31:0]   cur_word, wr_word, wdata_sh, load_val;
  logic [3:0]    be;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          commit, mem_we;

  // Decode the latched request: legality, lane selection, merged store word and load value
  always_comb begin
    offset       = addr_q - BASE_ADDR;
    idx          = offset[IW+1:2];
    out_of_range = (addr_q < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH_WORDS));
    is_half      = 1'b0;
    is_word      = 1'b0;
    bad_code     = 1'b0;
    if (we_q) begin
      case (scode_q)
        2'b00:   ;
        2'b01:   is_half = 1'b1;
        2'b10:   is_word = 1'b1;
        default: bad_code = 1'b1;
      endcase
    end else begin
      case (lcode_q)
        3'b000, 3'b100: ;
        3'b001, 3'b101: is_half = 1'b1;
        3'b010:         is_word = 1'b1;
        default:        bad_code = 1'b1;
      endcase
    end
    misaligned = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
    acc_err    = bad_code || misaligned || out_of_range;

    cur_word = mem[idx];
    if (is_word) begin
      be       = 4'b1111;
      wdata_sh = wdata_q;
    end else if (is_half) begin
      be       = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_sh = {2{wdata_q[15:0]}};
    end else begin
      be       = 4'(4'b0001 << addr_q[1:0]);
      wdata_sh = {4{wdata_q[7:0]}};
    end
    wr_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = wdata_sh[8*i +: 8];
    end

    byte_sel = cur_word[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? cur_word[31:16] : cur_word[15:0];
    case (lcode_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = cur_word;
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = 32'd0;
    endcase

    commit = (state == S_WAIT) && (cnt == '0);
    mem_we = commit && we_q && !acc_err;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lcode_d = lcode_q;
    scode_d = scode_q;
    ready_d = req_ready;
    valid_d = rsp_valid;
    rdata_d = rsp_rdata;
    err_d   = rsp_err;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lcode_d = req_load_code;
          scode_d = req_store_code;
          cnt_d   = CW'(LATENCY - 1);
          ready_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          valid_d = 1'b1;
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'd0 : load_val;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        rdata_d = 32'd0;
        err_d   = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched request and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      lcode_q   <= 3'd0;
      scode_q   <= 2'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lcode_q   <= lcode_d;
      scode_q   <= scode_d;
      req_ready <= ready_d;
      rsp_valid <= valid_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end
  end

  // Array write in the commit cycle only; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder with a byte-level memory model.
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_load_code = 3'd0;
  logic [1:0]  req_store_code = 2'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_load_code(req_load_code), .req_store_code(req_store_code),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mb [0:4*DEPTH-1];
  int          cycle = 0;
  int          errors = 0;
  int          checks = 0;
  int          rmode = 2;   // 0 random rsp_ready, 1 held low, 2 held high

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // rsp_ready changes just after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: byte-addressed memory, access size and legality from the code tables
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] lc, input logic [1:0] sc,
                                output logic [31:0] rd, output logic er);
    int     size;
    bit     sgn;
    bit     bad;
    longint off;
    longint v;
    size = 4; sgn = 0; bad = 0;
    if (we) begin
      case (sc)
        2'd0: size = 1;
        2'd1: size = 2;
        2'd2: size = 4;
        default: bad = 1;
      endcase
    end else begin
      case (lc)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: bad = 1;
      endcase
    end
    off = longint'({32'd0, addr}) - longint'({32'd0, BASE});
    if ((addr % size) != 0) bad = 1;
    if (off < 0 || off >= 4 * DEPTH) bad = 1;
    rd = 32'd0;
    er = bad;
    if (!bad) begin
      if (we) begin
        for (int i = 0; i < size; i++) mb[int'(off) + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (longint'(mb[int'(off) + i]) << (8 * i));
        if (sgn && v[8*size-1]) v = v - (longint'(1) << (8 * size));
        rd = v[31:0];
      end
    end
  endfunction

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] lc, input logic [1:0] sc, output bit ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_load_code = lc; req_store_code = sc;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed %b expected 1", req_ready);
      req_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] lc, input logic [1:0] sc);
    exp_t e;
    bit   ok;
    drive(we, addr, wdata, lc, sc, ok);
    if (ok) begin
      model(we, addr, wdata, lc, sc, e.rdata, e.err);
      e.acc = cycle + 1;
      sbq.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: latency, hold-stability and scoreboard compare
  initial begin : monitor
    logic        prev_v;
    int          rise_c;
    logic [31:0] hold_d;
    logic        hold_e;
    exp_t        e;
    prev_v = 1'b0; rise_c = 0; hold_d = 32'd0; hold_e = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (rsp_valid && !prev_v) begin
          rise_c = cycle; hold_d = rsp_rdata; hold_e = rsp_err;
        end else if (rsp_valid) begin
          chk("hold_stable", {rsp_rdata ^ hold_d, 31'd0} >> 31 | 32'(rsp_err ^ hold_e), 32'd0);
        end
        if (rsp_valid) chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (rsp_valid && rsp_ready) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rdata %h err %b expected none", rsp_rdata, rsp_err);
          end else begin
            e = sbq.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("latency", 32'(rise_c), 32'(e.acc + int'(LAT)));
          end
        end
        prev_v = rsp_valid && !rsp_ready;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit          ok;
    logic [31:0] a, w;
    int          r;
    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    // Word store/load, sub-word stores and sign/zero-extended loads
    issue(1, BASE + 32'h10, 32'hDEADBEEF, 3'd0, 2'd2);
    issue(0, BASE + 32'h10, 32'd0, 3'd2, 2'd0);
    issue(1, BASE + 32'h13, 32'h000000A5, 3'd0, 2'd0);
    issue(0, BASE + 32'h13, 32'd0, 3'd0, 2'd0);
    issue(0, BASE + 32'h13, 32'd0, 3'd4, 2'd0);
    issue(0, BASE + 32'h10, 32'd0, 3'd2, 2'd0);
    issue(1, BASE + 32'h10, 32'h00008001, 3'd0, 2'd1);
    issue(0, BASE + 32'h10, 32'd0, 3'd1, 2'd0);
    issue(0, BASE + 32'h10, 32'd0, 3'd5, 2'd0);
    // Errors: misaligned, illegal codes, below base
    issue(0, BASE + 32'h11, 32'd0, 3'd1, 2'd0);
    issue(1, BASE + 32'h12, 32'h12345678, 3'd0, 2'd2);
    issue(0, BASE + 32'h10, 32'd0, 3'd2, 2'd0);
    issue(0, BASE + 32'h10, 32'd0, 3'd3, 2'd0);
    issue(1, BASE + 32'h10, 32'h55555555, 3'd0, 2'd3);
    issue(0, BASE - 32'd4, 32'd0, 3'd2, 2'd0);
    drain();

    // Back-pressure: response held, concurrent request refused
    rmode = 1;
    issue(0, BASE + 32'h10, 32'd0, 3'd2, 2'd0);
    r = 0;
    while (!rsp_valid && r < 50) begin @(negedge clk); r++; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h10;
      req_wdata = 32'h99999999; req_store_code = 2'd2;
      chk("blocked_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rmode = 2;
    r = 0;
    while (rsp_valid && r < 50) begin @(negedge clk); r++; end
    chk("ready_after_rsp", 32'(req_ready), 32'd1);
    drain();

    // Reset during WAIT aborts the store
    issue(1, BASE + 32'h20, 32'h11111111, 3'd0, 2'd2);
    drain();
    drive(1, BASE + 32'h20, 32'h22222222, 3'd0, 2'd2, ok);
    if (ok) begin
      @(posedge clk);
      #1 rst = 1'b1; req_valid = 1'b0;
      #1;
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_rsp_rdata", rsp_rdata, 32'd0);
      chk("abort_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
    end
    issue(0, BASE + 32'h20, 32'd0, 3'd2, 2'd0);

    // Top-of-array boundary
    issue(0, BASE + 32'(4 * DEPTH), 32'd0, 3'd2, 2'd0);
    issue(1, BASE + 32'(4 * (DEPTH - 1)), 32'hCAFEF00D, 3'd0, 2'd2);
    issue(0, BASE + 32'(4 * (DEPTH - 1)), 32'd0, 3'd2, 2'd0);
    issue(0, BASE + 32'(4 * DEPTH - 1), 32'd0, 3'd0, 2'd0);
    drain();

    // Prefill the random window so every in-range load reads defined data
    for (int i = 0; i < 16; i++) issue(1, BASE + 32'(4 * i), $urandom, 3'd0, 2'd2);
    issue(1, BASE + 32'(4 * (DEPTH - 2)), $urandom, 3'd0, 2'd2);

    // Random traffic with random back-pressure and idle gaps
    rmode = 0;
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + 32'($urandom_range(0, 63));
      else if (r == 7) a = BASE + 32'(4 * DEPTH - 8) + 32'($urandom_range(0, 15));
      else if (r == 8) a = BASE - 32'($urandom_range(1, 8));
      else             a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      w = $urandom;
      issue(1'($urandom), a, w, 3'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rmode = 2;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
